// File: rtl/uart_core.sv
// uart_core: UART transceiver (1 start, 8 data LSB-first, 1 stop) with baud generator and 16x-oversampling receiver.
// Define UART_PARITY_EN to make errdata report even-parity failures over the received byte; otherwise errdata is tied 0.
module uart_core #(
   parameter int RX_DIV     = 4,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       write_enable,
   output logic       tx,
   output logic       busy,
   input  logic       rx,
   input  logic       state_clear,
   output logic       ready,
   output logic       errdata,
   output logic       enderror,
   output logic [7:0] rx_data
);
   localparam int TX_DIV = RX_DIV * OVERSAMPLE;
   localparam int RW     = $clog2(RX_DIV);
   localparam int TW     = $clog2(TX_DIV);
   localparam int OW     = $clog2(OVERSAMPLE);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

   logic [RW-1:0] rx_div_q, rx_div_d;
   logic [TW-1:0] tx_div_q, tx_div_d;
   logic          rx_clk_en, tx_clk_en;

   tx_state_t     tx_state_q, tx_state_d;
   logic [7:0]    tx_sh_q, tx_sh_d, pend_q, pend_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic          pend_v_q, pend_v_d, busy_q, busy_d;

   rx_state_t     rx_state_q, rx_state_d;
   logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
   logic [OW-1:0] os_q, os_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic          ready_q, ready_d, errdata_q, errdata_d, enderror_q, enderror_d;
   logic          par_err, fall;

`ifdef UART_PARITY_EN
   assign par_err = ^rx_sh_q;
`else
   assign par_err = 1'b0;
`endif

   // Free-running dividers giving one-cycle oversample and bit strobes
   always_comb begin
      rx_clk_en = rx_div_q == RW'(RX_DIV - 1);
      tx_clk_en = tx_div_q == TW'(TX_DIV - 1);
      rx_div_d  = rx_clk_en ? '0 : rx_div_q + 1'b1;
      tx_div_d  = tx_clk_en ? '0 : tx_div_q + 1'b1;
   end

   // Transmitter: pending-byte load, then START/DATA/STOP one bit period each; a pending byte chains straight out of STOP
   always_comb begin
      tx_state_d = tx_state_q;
      tx_sh_d    = tx_sh_q;
      tx_bit_d   = tx_bit_q;
      pend_d     = pend_q;
      pend_v_d   = pend_v_q;
      busy_d     = busy_q;
      if (tx_clk_en) begin
         case (tx_state_q)
            TX_IDLE, TX_STOP: begin
               tx_state_d = pend_v_q ? TX_START : TX_IDLE;
               if (pend_v_q) begin
                  tx_sh_d  = pend_q;
                  pend_v_d = 1'b0;
               end
            end
            TX_START: begin
               tx_state_d = TX_DATA;
               tx_bit_d   = 3'd0;
            end
            TX_DATA: begin
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  busy_d     = 1'b0;
               end
            end
            default: tx_state_d = TX_IDLE;
         endcase
      end
      if (write_enable && !busy_q) begin
         pend_d   = tx_data;
         pend_v_d = 1'b1;
         busy_d   = 1'b1;
      end
   end

   assign tx   = (tx_state_q == TX_START) ? 1'b0 : (tx_state_q == TX_DATA) ? tx_sh_q[0] : 1'b1;
   assign busy = busy_q;

   // Receiver: synchronise rx, detect the start edge, sample mid-bit and post the frame into sticky flags
   always_comb begin
      rx_s1_d    = rx;
      rx_s2_d    = rx_s1_q;
      rx_prev_d  = rx_s2_q;
      fall       = rx_prev_q & ~rx_s2_q;
      rx_state_d = rx_state_q;
      os_d       = os_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      ready_d    = state_clear ? 1'b0 : ready_q;
      errdata_d  = state_clear ? 1'b0 : errdata_q;
      enderror_d = state_clear ? 1'b0 : enderror_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (fall) begin
               rx_state_d = RX_START;
               os_d       = '0;
            end
         end
         RX_START: begin
            if (rx_clk_en) begin
               os_d = os_q + 1'b1;
               if (os_q == OW'(OVERSAMPLE / 2 - 1)) begin
                  os_d       = '0;
                  rx_bit_d   = 3'd0;
                  rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (rx_clk_en) begin
               os_d = os_q + 1'b1;
               if (os_q == OW'(OVERSAMPLE - 1)) begin
                  os_d     = '0;
                  rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                  rx_bit_d = rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (rx_clk_en) begin
               os_d = os_q + 1'b1;
               if (os_q == OW'(OVERSAMPLE - 1)) begin
                  os_d       = '0;
                  rx_data_d  = rx_sh_q;
                  ready_d    = 1'b1;
                  errdata_d  = par_err;
                  enderror_d = ~rx_s2_q;
                  rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT;
               end
            end
         end
         RX_WAIT: rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   assign ready    = ready_q;
   assign errdata  = errdata_q;
   assign enderror = enderror_q;
   assign rx_data  = rx_data_q;

   // State registers; reset aborts any frame in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_div_q   <= '0;
         tx_div_q   <= '0;
         tx_state_q <= TX_IDLE;
         tx_sh_q    <= '0;
         tx_bit_q   <= '0;
         pend_q     <= '0;
         pend_v_q   <= 1'b0;
         busy_q     <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         os_q       <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         ready_q    <= 1'b0;
         errdata_q  <= 1'b0;
         enderror_q <= 1'b0;
      end else begin
         rx_div_q   <= rx_div_d;
         tx_div_q   <= tx_div_d;
         tx_state_q <= tx_state_d;
         tx_sh_q    <= tx_sh_d;
         tx_bit_q   <= tx_bit_d;
         pend_q     <= pend_d;
         pend_v_q   <= pend_v_d;
         busy_q     <= busy_d;
         rx_state_q <= rx_state_d;
         rx_s1_q    <= rx_s1_d;
         rx_s2_q    <= rx_s2_d;
         rx_prev_q  <= rx_prev_d;
         os_q       <= os_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         ready_q    <= ready_d;
         errdata_q  <= errdata_d;
         enderror_q <= enderror_d;
      end
   end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: loopback/random bench for uart_core against a bit-timeline model of the serial line and host flags.
module tb_uart_core;
`ifdef UART_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   logic       clk = 1'b0, rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       write_enable = 1'b0, state_clear = 1'b0, loop = 1'b1, rx_drv = 1'b1;
   logic       tx, busy, rx, ready, errdata, enderror;
   logic [7:0] rx_data;
   int         total = 0, bad = 0;
   bit         rx_free = 1'b0;

   assign rx = loop ? tx : rx_drv;

   uart_core dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .write_enable(write_enable), .tx(tx), .busy(busy),
      .rx(rx), .state_clear(state_clear), .ready(ready), .errdata(errdata), .enderror(enderror), .rx_data(rx_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pbyte(input int i);
      logic [6:0] d;
      d = i[6:0];
      return {^d, d};
   endfunction

   function automatic logic par(input logic [7:0] b);
      return PAR_EN ? ^b : 1'b0;
   endfunction

   // Model: edge k counts clocks since reset; bit periods are 64 clocks and begin on edges with k%64==63.
   // A frame started on edge s drives bit i for edges s+64i..s+64i+63; busy drops at s+576; the receiver
   // posts the byte around s+608 (9.5 bits plus synchroniser delay), so rx outputs are left unchecked near then.
   typedef struct {int due; logic [7:0] b;} rxe_t;
   rxe_t       rq[$];
   int         k, m_s, e, bi;
   bit         m_act, m_pend, m_busy, ob, in_win;
   logic [7:0] m_byte, m_pbyte, m_data;
   logic       m_ready, m_err, m_end, etx;

   always begin
      @(posedge clk);
      if (!rst) begin
         k = 0; m_act = 0; m_pend = 0; m_busy = 0; in_win = 0;
         rq.delete();
         m_ready = 0; m_err = 0; m_end = 0; m_data = 8'h00;
      end else begin
         ob = m_busy;
         if (k % 64 == 63 && m_pend && (!m_act || k == m_s + 640)) begin
            m_act = 1; m_s = k; m_byte = m_pbyte; m_pend = 0;
            if (loop) rq.push_back('{k + 608, m_pbyte});
         end else if (m_act && k == m_s + 640) m_act = 0;
         if (m_act && k == m_s + 576) m_busy = 0;
         if (write_enable && !ob) begin
            m_pend = 1; m_pbyte = tx_data; m_busy = 1;
         end
         if (state_clear) begin
            m_ready = 0; m_err = 0; m_end = 0;
         end
         in_win = rq.size() > 0 && k >= rq[0].due - 3;
         if (rq.size() > 0 && k == rq[0].due + 4) begin
            m_ready = 1; m_data = rq[0].b; m_err = par(rq[0].b); m_end = 0;
            void'(rq.pop_front());
            in_win = 0;
         end
         k++;
      end
      etx = 1'b1;
      if (m_act) begin
         e = k - 1;
         bi = (e - m_s) / 64;
         etx = (bi == 0) ? 1'b0 : (bi <= 8) ? m_byte[bi-1] : 1'b1;
      end
      #1;
      chk("tx", tx, etx);
      chk("busy", busy, m_busy);
      if (!rx_free && !in_win) begin
         chk("ready", ready, m_ready);
         chk("errdata", errdata, m_err);
         chk("enderror", enderror, m_end);
         chk("rx_data", rx_data, m_data);
      end
   end

   task automatic send(input logic [7:0] b, input int n);
      @(negedge clk);
      tx_data = b;
      write_enable = 1'b1;
      repeat (n) @(negedge clk);
      write_enable = 1'b0;
   endtask

   task automatic wait_ready(input string name, input int lim);
      for (int i = 0; i < lim && ready !== 1'b1; i++) @(negedge clk);
      total++;
      if (ready !== 1'b1) begin
         bad++;
         $display("FAIL %s: ready got %b want 1 within %0d clks", name, ready, lim);
      end
   endtask

   task automatic clear();
      repeat (8) @(negedge clk);
      state_clear = 1'b1;
      repeat (2) @(negedge clk);
      state_clear = 1'b0;
   endtask

   logic [7:0] rb;

   initial begin
      repeat (4) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 0);
      chk("rst_errdata", errdata, 0);
      chk("rst_enderror", enderror, 0);
      chk("rst_rx_data", rx_data, 8'h00);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      send(8'h81, 2);
      chk("busy_after_load", busy, 1);
      wait_ready("first_frame", 1500);
      chk("first_rx_data", rx_data, 8'h81);
      chk("first_errdata", errdata, 0);
      chk("first_enderror", enderror, 0);
      clear();
      repeat (60) @(negedge clk);

      send(pbyte(1), 1);
      for (int i = 1; i <= 11; i++) begin
         wait_ready("seq_frame", 1500);
         chk("seq_rx_data", rx_data, pbyte(i));
         clear();
         chk("seq_cleared", ready, 0);
         if (i < 11) send(pbyte(i + 1), 1);
      end
      chk("seq_last", rx_data, 8'h8B);
      repeat (80) @(negedge clk);

      send(8'h01, 1);
      wait_ready("bad_parity", 1500);
      chk("bad_parity_data", rx_data, 8'h01);
      chk("bad_parity_err", errdata, PAR_EN ? 8'h01 : 8'h00);
      clear();
      repeat (80) @(negedge clk);

      send(8'h55, 1);
      repeat (100) @(negedge clk);
      send(8'hAA, 3);
      wait_ready("drop_busy", 1500);
      chk("drop_busy_data", rx_data, 8'h55);
      clear();

      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(0, 300)) @(negedge clk);
         rb = 8'($urandom);
         send(rb, $urandom_range(1, 4));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            send(~rb, 1);
         end
         wait_ready("rand_frame", 1500);
         chk("rand_rx_data", rx_data, rb);
         clear();
      end
      repeat (700) @(negedge clk);

      rx_free = 1'b1;
      loop = 1'b0;
      rx_drv = 1'b0;
      repeat (704) @(negedge clk);
      chk("break_ready", ready, 1);
      chk("break_enderror", enderror, 1);
      chk("break_rx_data", rx_data, 8'h00);
      clear();
      repeat (300) @(negedge clk);
      chk("break_no_rearm", ready, 0);
      rx_drv = 1'b1;
      repeat (700) @(negedge clk);
      chk("break_idle", ready, 0);

      loop = 1'b1;
      send(8'hC3, 1);
      repeat (300) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      rx_free = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      loop = 1'b0;
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (800) @(negedge clk);
      chk("glitch_ready", ready, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
